equiv_miscompare_monitor: RTL

//  Downstream consumer of a dual-instance equivalence harness (top_1/top_2 pair driven from shared clk/wire0..wire3).

---
 rtl/equiv_miscompare_monitor_if.sv | 32 +++
 rtl/equiv_miscompare_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/equiv_miscompare_monitor_if.sv
// Bus bundle between an equivalence harness and equiv_miscompare_monitor:
// per-cycle compare inputs plus the registered diagnostics coming back.
interface equiv_miscompare_monitor_if #(
  parameter int WIDTH = 91,
  parameter int CNT_W = 16
) ();
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] y_1;
  logic [WIDTH-1:0] y_2;
  logic             mismatch;
  logic             fail;
  logic [1:0]       state;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] first_fail_cycle;
  logic [WIDTH-1:0] first_y_1;
  logic [WIDTH-1:0] first_y_2;
  logic [WIDTH-1:0] diff_vec;

  modport master (
    output en, clr, y_1, y_2,
    input  mismatch, fail, state, mismatch_cnt, cycle_cnt,
           first_fail_cycle, first_y_1, first_y_2, diff_vec
  );

  modport slave (
    input  en, clr, y_1, y_2,
    output mismatch, fail, state, mismatch_cnt, cycle_cnt,
           first_fail_cycle, first_y_1, first_y_2, diff_vec
  );
endinterface

// File: rtl/equiv_miscompare_monitor.sv
// Sticky miscompare diagnostics for a dual-instance equivalence harness.
// Optional macro EQMON_DIFF_CAPTURE_EN builds the accumulated divergent-bit vector (diff_vec).
module equiv_miscompare_monitor #(
  parameter int WIDTH         = 91,
  parameter int WARMUP_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  equiv_miscompare_monitor_if.slave   mon
);

  localparam int WARM_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'b00,
    ST_COMPARE = 2'b01,
    ST_FAILED  = 2'b10
  } state_e;

  // With no warm-up window the monitor starts out comparing.
  localparam state_e            INIT_STATE = (WARMUP_CYCLES == 0) ? ST_COMPARE : ST_WARMUP;
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP_CYCLES);

  function automatic logic any_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return |(a ^ b);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic               mismatch_q, mismatch_d;
  logic               fail_q, fail_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic [CNT_W-1:0]   ccnt_q, ccnt_d;
  logic [CNT_W-1:0]   ffc_q, ffc_d;
  logic [WIDTH-1:0]   fy1_q, fy1_d;
  logic [WIDTH-1:0]   fy2_q, fy2_d;
  logic               diff_s;
`ifdef EQMON_DIFF_CAPTURE_EN
  logic [WIDTH-1:0]   diff_vec_q, diff_vec_d;
`endif

  assign diff_s = any_diff(mon.y_1, mon.y_2);

  // Next-state and diagnostic update logic.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    mcnt_d     = mcnt_q;
    ccnt_d     = ccnt_q;
    ffc_d      = ffc_q;
    fy1_d      = fy1_q;
    fy2_d      = fy2_q;
`ifdef EQMON_DIFF_CAPTURE_EN
    diff_vec_d = diff_vec_q;
`endif
    if (mon.clr) begin
      state_d    = INIT_STATE;
      warm_d     = '0;
      mismatch_d = 1'b0;
      fail_d     = 1'b0;
      mcnt_d     = '0;
      ccnt_d     = '0;
      ffc_d      = '0;
      fy1_d      = '0;
      fy2_d      = '0;
`ifdef EQMON_DIFF_CAPTURE_EN
      diff_vec_d = '0;
`endif
    end else begin
      case (state_q)
        ST_WARMUP: begin
          mismatch_d = 1'b0;
          if (mon.en) begin
            warm_d = warm_q + WARM_W'(1);
            if (warm_d == WARM_LAST) begin
              state_d = ST_COMPARE;
            end else begin
              state_d = ST_WARMUP;
            end
          end else begin
            warm_d = warm_q;
          end
        end
        ST_COMPARE: begin
          if (mon.en) begin
            ccnt_d     = sat_inc(ccnt_q);
            mismatch_d = diff_s;
            if (diff_s) begin
              mcnt_d  = sat_inc(mcnt_q);
              fail_d  = 1'b1;
              ffc_d   = ccnt_q;
              fy1_d   = mon.y_1;
              fy2_d   = mon.y_2;
              state_d = ST_FAILED;
            end else begin
              state_d = ST_COMPARE;
            end
          end else begin
            state_d = ST_COMPARE;
          end
        end
        ST_FAILED: begin
          // Captures and fail stay frozen here; only the counters keep moving.
          if (mon.en) begin
            ccnt_d     = sat_inc(ccnt_q);
            mismatch_d = diff_s;
            if (diff_s) begin
              mcnt_d = sat_inc(mcnt_q);
            end else begin
              mcnt_d = mcnt_q;
            end
          end else begin
            ccnt_d = ccnt_q;
          end
        end
        default: begin
          state_d = INIT_STATE;
        end
      endcase
`ifdef EQMON_DIFF_CAPTURE_EN
      if (mon.en && (state_q == ST_COMPARE || state_q == ST_FAILED)) begin
        diff_vec_d = diff_vec_q | (mon.y_1 ^ mon.y_2);
      end else begin
        diff_vec_d = diff_vec_q;
      end
`endif
    end
  end

  // State and diagnostic registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_STATE;
      warm_q     <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= 1'b0;
      mcnt_q     <= '0;
      ccnt_q     <= '0;
      ffc_q      <= '0;
      fy1_q      <= '0;
      fy2_q      <= '0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      mcnt_q     <= mcnt_d;
      ccnt_q     <= ccnt_d;
      ffc_q      <= ffc_d;
      fy1_q      <= fy1_d;
      fy2_q      <= fy2_d;
    end
  end

`ifdef EQMON_DIFF_CAPTURE_EN
  // Accumulated divergent-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_vec_q <= '0;
    end else begin
      diff_vec_q <= diff_vec_d;
    end
  end

  assign mon.diff_vec = diff_vec_q;
`else
  assign mon.diff_vec = '0;
`endif

  assign mon.mismatch         = mismatch_q;
  assign mon.fail             = fail_q;
  assign mon.state            = state_q;
  assign mon.mismatch_cnt     = mcnt_q;
  assign mon.cycle_cnt        = ccnt_q;
  assign mon.first_fail_cycle = ffc_q;
  assign mon.first_y_1        = fy1_q;
  assign mon.first_y_2        = fy2_q;

endmodule
